// File: rtl/efpga_cfg_loader.sv
// Configuration bitstream loader for the eFPGA fabric wrapper: unpacks framed sections into
// prog_i / prog_shft and verifies each section with an XOR trailer before enabling the fabric.
module efpga_cfg_loader #(
    parameter int unsigned NCHAIN = 9,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              clk,
    input  logic              nres,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [31:0]       cfg_data,
    input  logic              cfg_clear,
    output logic [31:0]       prog_i,
    output logic [NCHAIN-1:0] prog_shft,
    output logic              fab_en,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t            state, state_d;
    logic [NCHAIN-1:0] mask_q, mask_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       prog_i_d;
    logic [NCHAIN-1:0] prog_shft_d;
    logic              ready_d;
    logic              xfer;
    logic              hdr_bad;

    assign xfer    = cfg_valid & cfg_ready;
    assign hdr_bad = (cfg_data[31:24] != 8'hA5)
                   || (cfg_data[15 +: NCHAIN] == '0)
                   || (cfg_data[LEN_W-1:0] == '0)
                   || (cfg_data[13:12] != 2'b00);

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state     <= HDR;
            mask_q    <= '0;
            last_q    <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            csum_q    <= '0;
            prog_i    <= '0;
            prog_shft <= '0;
            cfg_ready <= 1'b0;
        end else begin
            state     <= state_d;
            mask_q    <= mask_d;
            last_q    <= last_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            prog_i    <= prog_i_d;
            prog_shft <= prog_shft_d;
            cfg_ready <= ready_d;
        end
    end

    always_comb begin
        state_d     = state;
        mask_d      = mask_q;
        last_d      = last_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        prog_i_d    = prog_i;
        prog_shft_d = '0;

        // Clear wins over a coincident transfer; the offered word is simply dropped.
        if (cfg_clear) begin
            state_d = HDR;
            cnt_d   = '0;
            csum_d  = '0;
        end else begin
            unique case (state)
                HDR: begin
                    if (xfer) begin
                        if (hdr_bad) begin
                            state_d = ERR;
                        end else begin
                            mask_d  = cfg_data[15 +: NCHAIN];
                            last_d  = cfg_data[14];
                            len_d   = cfg_data[LEN_W-1:0];
                            cnt_d   = '0;
                            csum_d  = '0;
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        prog_i_d    = cfg_data;
                        prog_shft_d = mask_q;
                        csum_d      = csum_q ^ cfg_data;
                        cnt_d       = cnt_q + LEN_ONE;
                        if (cnt_q == len_q - LEN_ONE) begin
                            state_d = CHK;
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        if (cfg_data != csum_q) begin
                            state_d = ERR;
                        end else if (last_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = HDR;
                        end
                    end
                end
                DONE: state_d = DONE;
                ERR:  state_d = ERR;
                default: state_d = ERR;
            endcase
        end

        ready_d = (state_d == HDR) || (state_d == DATA) || (state_d == CHK);
    end

    assign cfg_done = (state == DONE);
    assign cfg_err  = (state == ERR);
    assign cfg_busy = (state == DATA) || (state == CHK);
    assign fab_en   = cfg_done;

endmodule

// File: doc/efpga_cfg_loader.md
Name: efpga_cfg_loader

Overview:
Bitstream loader that sits directly upstream of the eFPGA fabric wrapper. It accepts a framed 32-bit configuration stream over a valid/ready handshake and converts it into the fabric's prog_i word and per-chain prog_shft strobes. It checks framing and a per-section XOR checksum, and raises fab_en to gate the fabric's data_en only once the whole stream has loaded cleanly.

Parameters:
NCHAIN, 9, number of configuration shift chains; width of prog_shft and of the header chain mask.
LEN_W, 12, width of the per-section payload word counter.

Ports:
clk  input  1  system clock
nres  input  1  asynchronous active-low reset
cfg_valid  input  1  upstream word valid
cfg_ready  output  1  loader can accept a word
cfg_data  input  32  configuration stream word
cfg_clear  input  1  synchronous restart: return to header state, clear done/err
prog_i  output  32  config word to fabric
prog_shft  output  NCHAIN  per-chain shift strobe, one cycle per payload word
fab_en  output  1  fabric user-data enable (equals cfg_done)
cfg_busy  output  1  a section is in progress (DATA or CHK)
cfg_done  output  1  last section loaded with correct checksum; sticky
cfg_err  output  1  framing or checksum error; sticky

Behaviour:
- Reset (nres low, async): state=HDR; prog_i=0, prog_shft=0, cfg_done=0, cfg_err=0, cfg_busy=0, cfg_ready=0, checksum=0, counter=0.
- cfg_ready is a registered flag. It rises on the first clk edge after nres deasserts. It is 1 in HDR/DATA/CHK and 0 in DONE/ERR.
- A word transfers only on a clk edge with cfg_valid & cfg_ready. Words with cfg_valid low are ignored. Stalls of any length are allowed.
- Header word format:
  - [31:24] magic = 8'hA5.
  - [23:15] chain mask (NCHAIN bits).
  - [14] last-section flag.
  - [13:12] reserved, must be 0.
  - [11:0] payload length N.
- HDR state, on transfer:
  - Magic != A5, mask == 0, N == 0, or reserved != 0 -> ERR.
  - Otherwise latch mask, last flag and N; clear checksum; counter=0; go to DATA.
- DATA state, on transfer:
  - The cycle after the transfer: prog_i=cfg_data and prog_shft=mask, both for exactly one cycle. Latency is 1.
  - prog_shft=0 on every cycle without a payload transfer. prog_i holds its last value.
  - checksum ^= cfg_data; counter+1. When counter reaches N-1 on this transfer -> CHK.
- CHK state, on transfer:
  - cfg_data != checksum -> ERR.
  - Else if last flag -> DONE; else -> HDR.
- DONE: cfg_done=1, fab_en=1, cfg_ready=0. Remains here until cfg_clear or reset.
- ERR: cfg_err=1, cfg_done=0, fab_en=0, cfg_ready=0, prog_shft=0. Remains here until cfg_clear or reset.
- cfg_busy=1 in DATA and CHK only.
- cfg_clear: takes priority over any transfer in the same cycle. Next state is HDR; done, err, checksum and counter are cleared; prog_shft=0 next cycle; cfg_ready=1 next cycle. A clear mid-section abandons that section. Words already shifted into the fabric are not undone.
- fab_en drops to 0 on the cycle after cfg_clear, before any reload begins.
- Reset mid-section: immediate return to the reset values above. A new stream must restart from a header.
- Counter and length are LEN_W bits, so N=4095 is the maximum. There is no wrap, because the section ends at N.

Test Plan:
- Single section: header 0xA5_00_C0_03 (mask 9'h001, last=1, N=3); payload 0x11111111, 0x22222222, 0x44444444; trailer 0x77777777. Expect 3 single-cycle prog_shft=9'h001 pulses with matching prog_i, each 1 cycle after its transfer. cfg_done=1, fab_en=1 and cfg_ready=0 after the trailer.
- Two sections, mask 9'h003 (last=0, N=1) then mask 9'h100 (last=1, N=2), with correct trailers. Expect prog_shft=003 once, then 100 twice. cfg_done asserts only after the second trailer; cfg_busy=0 between the sections.
- Bad checksum: N=1 payload 0xDEADBEEF, trailer 0xDEADBEEE. Expect cfg_err=1, cfg_done=0, cfg_ready=0; later words are ignored and prog_shft stays 0.
- Framing errors: header magic 0x5A -> ERR. Then cfg_clear, then a header with N=0 -> ERR. Then cfg_clear, then a valid stream -> DONE.
- Backpressure/idle: insert random cfg_valid=0 gaps inside the payload. Expect the prog_shft pulse count to equal N exactly, in order, with no duplicates.
- Reset and clear mid-operation: assert nres low after 2 of 4 payload words -> all outputs return to reset values asynchronously. Assert cfg_clear while in DONE -> fab_en=0 next cycle and state returns to HDR. Assert cfg_clear together with a valid transfer -> the word is dropped.
